if_prefetch: RTL and testbench

Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register of the 5-stage RISC-V core. It issues word fetches to a variable-latency instruction memory and buffers the returned words in a small prefetch queue. It presents {pc, instruction} pairs to the decode stage with a valid/ready handshake. Branch, JAL and JALR redirects from EX/ID flush the queue and squash any in-flight fetch, replacing the single-cycle `PC`/`PCWrite` path.

---
 rtl/if_prefetch.sv | 147 ++++++++++++++
 tb/tb_if_prefetch.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: single-outstanding imem fetcher feeding a DEPTH-entry {pc, instr} queue.
// Define IF_PREFETCH_PERF_EN to add the perf_fetched / perf_discarded counters.
module if_prefetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk_1s,
    input  logic        rstn,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        id_ready
`ifdef IF_PREFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_discarded
`endif
);
    localparam int unsigned   PW      = $clog2(DEPTH);
    localparam int unsigned   CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];

    logic          ack_v, drop, enq, deq, can_issue;
    logic [31:0]   tgt_pc;
    logic          unused_pc_lsbs;

    assign ack_v          = imem_ack && req_q;
    assign drop           = (state_q == DRAIN) || redirect_valid;
    assign enq            = ack_v && !drop;
    assign deq            = (count_q != '0) && id_ready && !redirect_valid;
    assign tgt_pc         = {redirect_pc[31:2], 2'b00};
    assign can_issue      = !req_q || ack_v;
    assign unused_pc_lsbs = ^redirect_pc[1:0];

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        if (redirect_valid) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = tgt_pc;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
            if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(enq) - CW'(deq);
        end

        // Issue decision sees the post-redirect fetch_pc and the updated occupancy.
        if (can_issue) begin
            if (count_d < DEPTH_C) begin
                req_d      = 1'b1;
                addr_d     = fetch_pc_d;
                fetch_pc_d = fetch_pc_d + 32'd4;
                state_d    = BUSY;
            end else begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        end else if (redirect_valid) begin
            state_d = DRAIN;
        end
    end

    always_ff @(posedge clk_1s or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            if (enq) begin
                pc_mem_q[wr_ptr_q]    <= addr_q;
                instr_mem_q[wr_ptr_q] <= imem_rdata;
            end
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign if_valid  = (count_q != '0);
    assign if_pc     = pc_mem_q[rd_ptr_q];
    assign if_instr  = instr_mem_q[rd_ptr_q];

`ifdef IF_PREFETCH_PERF_EN
    logic [31:0] fetched_q, discarded_q;
    logic [32:0] fetched_sum, discarded_sum;

    // Discards = dropped acks plus whatever valid entries a redirect flushes.
    always_comb begin
        fetched_sum   = {1'b0, fetched_q} + 33'(enq);
        discarded_sum = {1'b0, discarded_q} + 33'(ack_v && drop)
                        + (redirect_valid ? 33'(count_q) : 33'd0);
    end

    always_ff @(posedge clk_1s or negedge rstn) begin
        if (!rstn) begin
            fetched_q   <= '0;
            discarded_q <= '0;
        end else begin
            fetched_q   <= fetched_sum[32]   ? '1 : fetched_sum[31:0];
            discarded_q <= discarded_sum[32] ? '1 : discarded_sum[31:0];
        end
    end

    assign perf_fetched   = fetched_q;
    assign perf_discarded = discarded_q;
`endif
endmodule

// File: tb/tb_if_prefetch.sv
// Scoreboard bench for if_prefetch: a behavioural variable-latency imem plus in-order PC/instr checks.
module tb_if_prefetch;
    logic        clk_1s = 1'b0;
    logic        rstn   = 1'b1;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        id_ready;
`ifdef IF_PREFETCH_PERF_EN
    logic [31:0] perf_fetched, perf_discarded;
`endif

    int          checks = 0;
    int          errors = 0;
    int          lat    = 1;
    int          wc     = 0;
    logic        req_prev;
    logic [31:0] sb [$];

    always #5 clk_1s = ~clk_1s;

    if_prefetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk_1s(clk_1s), .rstn(rstn),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .id_ready(id_ready)
`ifdef IF_PREFETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_discarded(perf_discarded)
`endif
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Memory acks `lat` cycles after it first sees a request; lat = 0 acks in the request cycle.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clk_1s);
            if (!rstn || !imem_req) begin
                imem_ack = 1'b0;
                wc = 0;
            end else if (wc >= lat) begin
                imem_ack   = 1'b1;
                imem_rdata = word_at(imem_addr);
                wc = 0;
            end else begin
                imem_ack = 1'b0;
                wc++;
            end
        end
    end

    task automatic do_reset(input int l);
        rstn = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        id_ready = 1'b0;
        lat = l;
        req_prev = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk_1s);
        rstn = 1'b1;
    endtask

    task automatic test_reset;
        #2 rstn = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_valid); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", if_pc); end
        checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", if_instr); end
        do_reset(1);
        @(posedge clk_1s); #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0)
            begin errors++; $display("FAIL first_req: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); end
    endtask

    task automatic test_sequential;
        logic [31:0] exp_addr = 32'h0;
        logic [31:0] e;
        int issued = 0;
        do_reset(1);
        id_ready = 1'b1;
        for (int i = 0; i < 8; i++) sb.push_back(32'(i * 4));
        for (int cyc = 0; cyc < 100 && sb.size() != 0; cyc++) begin
            @(posedge clk_1s); #1;
            if (imem_req && (!req_prev || imem_ack) && issued < 8) begin
                checks++; if (imem_addr !== exp_addr) begin errors++; $display("FAIL seq_addr: got %h want %h", imem_addr, exp_addr); end
                exp_addr += 32'd4;
                issued++;
            end
            req_prev = imem_req;
            if (if_valid && id_ready) begin
                e = sb.pop_front();
                checks++; if (if_pc !== e) begin errors++; $display("FAIL seq_pc: got %h want %h", if_pc, e); end
                checks++; if (if_instr !== word_at(e)) begin errors++; $display("FAIL seq_instr: got %h want %h", if_instr, word_at(e)); end
            end
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL seq_timeout: got %0d left want 0", sb.size()); end
    endtask

    task automatic test_full;
        int acks = 0;
        do_reset(0);
        repeat (12) begin
            @(posedge clk_1s); #1;
            if (imem_ack) acks++;
        end
        checks++; if (acks != 4) begin errors++; $display("FAIL full_acks: got %0d want 4", acks); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL full_req: got %b want 0", imem_req); end
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0)
            begin errors++; $display("FAIL full_head: got v=%b pc=%h want v=1 pc=0", if_valid, if_pc); end
        checks++; if (if_instr !== word_at(32'h0)) begin errors++; $display("FAIL full_instr: got %h want %h", if_instr, word_at(32'h0)); end
`ifdef IF_PREFETCH_PERF_EN
        checks++; if (perf_fetched !== 32'd4) begin errors++; $display("FAIL perf_fetched: got %0d want 4", perf_fetched); end
`endif
        id_ready = 1'b1;
        @(posedge clk_1s); #1;
        id_ready = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10)
            begin errors++; $display("FAIL full_resume: got req=%b addr=%h want req=1 addr=10", imem_req, imem_addr); end
        checks++; if (if_pc !== 32'h4) begin errors++; $display("FAIL full_next_pc: got %h want 4", if_pc); end
    endtask

    task automatic test_redirect_idle;
        logic [31:0] e;
`ifdef IF_PREFETCH_PERF_EN
        logic [31:0] disc0;
`endif
        do_reset(0);
        repeat (10) @(posedge clk_1s);
        #1;
`ifdef IF_PREFETCH_PERF_EN
        disc0 = perf_discarded;
`endif
        redirect_valid = 1'b1;
        redirect_pc = 32'h103;
        @(posedge clk_1s); #1;
        redirect_valid = 1'b0;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rdi_valid: got %b want 0", if_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100)
            begin errors++; $display("FAIL rdi_req: got req=%b addr=%h want req=1 addr=100", imem_req, imem_addr); end
`ifdef IF_PREFETCH_PERF_EN
        checks++; if (perf_discarded - disc0 !== 32'd4) begin errors++; $display("FAIL rdi_perf: got %0d want 4", perf_discarded - disc0); end
`endif
        sb.push_back(32'h100); sb.push_back(32'h104); sb.push_back(32'h108);
        id_ready = 1'b1;
        for (int cyc = 0; cyc < 50 && sb.size() != 0; cyc++) begin
            if (if_valid && id_ready) begin
                e = sb.pop_front();
                checks++; if (if_pc !== e || if_instr !== word_at(e))
                    begin errors++; $display("FAIL rdi_pop: got pc=%h instr=%h want pc=%h", if_pc, if_instr, e); end
            end
            @(posedge clk_1s); #1;
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL rdi_timeout: got %0d left want 0", sb.size()); end
    endtask

    task automatic test_redirect_drain;
        logic [31:0] e;
        bit fired = 0;
        bit want_first = 0;
`ifdef IF_PREFETCH_PERF_EN
        logic [31:0] disc0;
`endif
        do_reset(3);
        id_ready = 1'b1;
        sb.push_back(32'h0);
`ifdef IF_PREFETCH_PERF_EN
        disc0 = perf_discarded;
`endif
        for (int cyc = 0; cyc < 80 && !(fired && sb.size() == 0); cyc++) begin
            @(posedge clk_1s); #1;
            redirect_valid = 1'b0;
            if (imem_req && (!req_prev || imem_ack)) begin
                if (want_first) begin
                    checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL drain_req: got %h want 200", imem_addr); end
                    want_first = 0;
                end
                if (!fired && imem_addr == 32'h8) begin
                    redirect_valid = 1'b1;
                    redirect_pc = 32'h200;
                    fired = 1;
                    want_first = 1;
                    sb.delete();
                    sb.push_back(32'h200); sb.push_back(32'h204);
                end
            end
            req_prev = imem_req;
            if (if_valid && id_ready && !redirect_valid) begin
                e = (sb.size() != 0) ? sb.pop_front() : 32'hFFFF_FFFF;
                checks++; if (if_pc !== e || if_instr !== word_at(e))
                    begin errors++; $display("FAIL drain_pop: got pc=%h instr=%h want pc=%h", if_pc, if_instr, e); end
            end
        end
        checks++; if (!fired || sb.size() != 0) begin errors++; $display("FAIL drain_timeout: got fired=%0d left=%0d want 1/0", fired, sb.size()); end
`ifdef IF_PREFETCH_PERF_EN
        // The redirect flushes the queued 0x4 word and the 0x8 ack is dropped.
        checks++; if (perf_discarded - disc0 !== 32'd2) begin errors++; $display("FAIL drain_perf: got %0d want 2", perf_discarded - disc0); end
`endif
    endtask

    task automatic test_ack_deq_redirect;
        logic [31:0] e;
        do_reset(0);
        id_ready = 1'b1;
        for (int i = 0; i < 16; i++) sb.push_back(32'(i * 4));
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(posedge clk_1s); #1;
            if (if_valid && id_ready) begin
                e = sb.pop_front();
                checks++; if (if_pc !== e) begin errors++; $display("FAIL adr_pre: got %h want %h", if_pc, e); end
            end
        end
        checks++; if (if_valid !== 1'b1 || imem_req !== 1'b1)
            begin errors++; $display("FAIL adr_setup: got v=%b req=%b want 1/1", if_valid, imem_req); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        sb.delete();
        sb.push_back(32'h40); sb.push_back(32'h44); sb.push_back(32'h48);
        @(posedge clk_1s); #1;
        redirect_valid = 1'b0;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL adr_empty: got %b want 0", if_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40)
            begin errors++; $display("FAIL adr_req: got req=%b addr=%h want req=1 addr=40", imem_req, imem_addr); end
        for (int cyc = 0; cyc < 40 && sb.size() != 0; cyc++) begin
            @(posedge clk_1s); #1;
            if (if_valid && id_ready) begin
                e = sb.pop_front();
                checks++; if (if_pc !== e || if_instr !== word_at(e))
                    begin errors++; $display("FAIL adr_pop: got pc=%h instr=%h want pc=%h", if_pc, if_instr, e); end
            end
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL adr_timeout: got %0d left want 0", sb.size()); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] e;
        int acks = 0;
        bit first = 1;
        do_reset(3);
        for (int cyc = 0; cyc < 40 && acks < 2; cyc++) begin
            @(posedge clk_1s); #1;
            if (imem_ack) acks++;
        end
        checks++; if (acks != 2 || imem_req !== 1'b1)
            begin errors++; $display("FAIL rst_setup: got acks=%0d req=%b want 2/1", acks, imem_req); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0)
            begin errors++; $display("FAIL rst_imem: got req=%b addr=%h want 0/0", imem_req, imem_addr); end
        checks++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0)
            begin errors++; $display("FAIL rst_if: got v=%b pc=%h instr=%h want 0/0/0", if_valid, if_pc, if_instr); end
        @(negedge clk_1s);
        rstn = 1'b1;
        req_prev = 1'b0;
        id_ready = 1'b1;
        sb.push_back(32'h0); sb.push_back(32'h4);
        for (int cyc = 0; cyc < 40 && sb.size() != 0; cyc++) begin
            @(posedge clk_1s); #1;
            if (first && imem_req) begin
                checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_restart: got %h want 0", imem_addr); end
                first = 0;
            end
            if (if_valid && id_ready) begin
                e = sb.pop_front();
                checks++; if (if_pc !== e || if_instr !== word_at(e))
                    begin errors++; $display("FAIL rst_pop: got pc=%h instr=%h want pc=%h", if_pc, if_instr, e); end
            end
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL rst_timeout: got %0d left want 0", sb.size()); end
    endtask

    initial begin
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b0;
        req_prev       = 1'b0;
        test_reset;
        test_sequential;
        test_full;
        test_redirect_idle;
        test_redirect_drain;
        test_ack_deq_redirect;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
